// File: rtl/id_operand_unit_pkg.sv
// Shared definitions for the ID operand-resolution stage: default widths,
// control-bundle field layout and operand source selection.
package id_operand_unit_pkg;

  localparam int unsigned XLEN_DEF       = 32;
  localparam int unsigned REG_ADDR_W_DEF = 5;
  localparam int unsigned NUM_FWD_DEF    = 2;
  localparam int unsigned CNT_W_DEF      = 16;

  localparam int unsigned CTRL_ALUSEL_LSB = 0;
  localparam int unsigned CTRL_ALUSEL_W   = 3;
  localparam int unsigned CTRL_ALUOP_LSB  = CTRL_ALUSEL_LSB + CTRL_ALUSEL_W;
  localparam int unsigned CTRL_ALUOP_W    = 5;
  localparam int unsigned CTRL_MEMOFF_LSB = CTRL_ALUOP_LSB + CTRL_ALUOP_W;
  localparam int unsigned CTRL_MEMOFF_W   = 8;
  localparam int unsigned CTRL_W_DEF      = CTRL_MEMOFF_LSB + CTRL_MEMOFF_W;

  localparam int unsigned ZERO_REG = 0;

  typedef enum logic [2:0] {
    OPSRC_IMM,
    OPSRC_ZERO,
    OPSRC_FWD,
    OPSRC_WB,
    OPSRC_RF
  } op_src_e;

endpackage

// File: rtl/id_operand_unit_if.sv
// Decode-side and execute-side handshake bundle of the ID/EX operand stage.
interface id_operand_unit_if
  import id_operand_unit_pkg::*;
#(
  parameter int unsigned XLEN       = XLEN_DEF,
  parameter int unsigned REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int unsigned CTRL_W     = CTRL_W_DEF
);
  logic                  in_valid;
  logic                  in_ready;
  logic                  in_read1;
  logic                  in_read2;
  logic [REG_ADDR_W-1:0] in_rs1;
  logic [REG_ADDR_W-1:0] in_rs2;
  logic [XLEN-1:0]       in_imm1;
  logic [XLEN-1:0]       in_imm2;
  logic                  in_write;
  logic [REG_ADDR_W-1:0] in_rd;
  logic                  in_load;
  logic [CTRL_W-1:0]     in_ctrl;

  logic                  out_valid;
  logic                  out_ready;
  logic [XLEN-1:0]       out_op1;
  logic [XLEN-1:0]       out_op2;
  logic [REG_ADDR_W-1:0] out_rd;
  logic                  out_write;
  logic                  out_load;
  logic [CTRL_W-1:0]     out_ctrl;

  modport master (
    output in_valid, in_read1, in_read2, in_rs1, in_rs2, in_imm1, in_imm2,
           in_write, in_rd, in_load, in_ctrl, out_ready,
    input  in_ready, out_valid, out_op1, out_op2, out_rd, out_write, out_load, out_ctrl
  );

  modport slave (
    input  in_valid, in_read1, in_read2, in_rs1, in_rs2, in_imm1, in_imm2,
           in_write, in_rd, in_load, in_ctrl, out_ready,
    output in_ready, out_valid, out_op1, out_op2, out_rd, out_write, out_load, out_ctrl
  );
endinterface

// File: rtl/id_operand_unit_operand_resolve.sv
// Single-operand resolver: prioritised bypass mux (youngest source first)
// plus the hazard flag raised when the operand cannot be supplied yet.
module id_operand_unit_operand_resolve
  import id_operand_unit_pkg::*;
#(
  parameter int unsigned XLEN       = XLEN_DEF,
  parameter int unsigned REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int unsigned NUM_FWD    = NUM_FWD_DEF
) (
  input  logic                       read,
  input  logic [REG_ADDR_W-1:0]      addr,
  input  logic [XLEN-1:0]            imm,
  input  logic [XLEN-1:0]            rf_rdata,
  input  logic [NUM_FWD-1:0]         fwd_write,
  input  logic [NUM_FWD-1:0]         fwd_ready,
  input  logic [NUM_FWD*REG_ADDR_W-1:0] fwd_addr,
  input  logic [NUM_FWD*XLEN-1:0]    fwd_data,
  input  logic                       wb_clr,
  input  logic [REG_ADDR_W-1:0]      wb_clr_addr,
  input  logic [XLEN-1:0]            wb_clr_data,
  input  logic                       busy,
  output logic [XLEN-1:0]            data,
  output logic                       hazard
);

  logic            fwd_hit;
  logic            fwd_hit_ready;
  logic [XLEN-1:0] fwd_hit_data;
  op_src_e         src;

  // First matching source in index order wins.
  always_comb begin
    fwd_hit       = 1'b0;
    fwd_hit_ready = 1'b0;
    fwd_hit_data  = '0;
    for (int unsigned i = 0; i < NUM_FWD; i++) begin
      if (!fwd_hit && fwd_write[i] && (fwd_addr[i*REG_ADDR_W +: REG_ADDR_W] == addr)) begin
        fwd_hit       = 1'b1;
        fwd_hit_ready = fwd_ready[i];
        fwd_hit_data  = fwd_data[i*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    src    = OPSRC_RF;
    hazard = 1'b0;
    if (!read) begin
      src = OPSRC_IMM;
    end else if (addr == REG_ADDR_W'(ZERO_REG)) begin
      src = OPSRC_ZERO;
    end else if (fwd_hit) begin
      src    = OPSRC_FWD;
      hazard = !fwd_hit_ready;
    end else if (wb_clr && (wb_clr_addr == addr)) begin
      src = OPSRC_WB;
    end else if (busy) begin
      hazard = 1'b1;
    end
  end

  always_comb begin
    case (src)
      OPSRC_IMM:  data = imm;
      OPSRC_ZERO: data = '0;
      OPSRC_FWD:  data = fwd_hit_data;
      OPSRC_WB:   data = wb_clr_data;
      default:    data = rf_rdata;
    endcase
  end

endmodule

// File: rtl/id_operand_unit.sv
// ID/EX operand stage: resolves both operands, tracks outstanding loads in a
// per-register scoreboard and holds the result in a handshaked pipeline register.
module id_operand_unit
  import id_operand_unit_pkg::*;
#(
  parameter int unsigned XLEN       = XLEN_DEF,
  parameter int unsigned REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int unsigned NUM_FWD    = NUM_FWD_DEF,
  parameter int unsigned CTRL_W     = CTRL_W_DEF,
  parameter int unsigned CNT_W      = CNT_W_DEF
) (
  input  logic                          clk,
  input  logic                          reset,
  id_operand_unit_if.slave              bus,
  output logic [REG_ADDR_W-1:0]         rf_raddr1,
  output logic [REG_ADDR_W-1:0]         rf_raddr2,
  input  logic [XLEN-1:0]               rf_rdata1,
  input  logic [XLEN-1:0]               rf_rdata2,
  input  logic [NUM_FWD-1:0]            fwd_write,
  input  logic [NUM_FWD-1:0]            fwd_ready,
  input  logic [NUM_FWD*REG_ADDR_W-1:0] fwd_addr,
  input  logic [NUM_FWD*XLEN-1:0]       fwd_data,
  input  logic                          wb_clr,
  input  logic [REG_ADDR_W-1:0]         wb_clr_addr,
  input  logic [XLEN-1:0]               wb_clr_data,
  input  logic                          flush,
  output logic [CNT_W-1:0]              stall_cycles
);

  localparam int unsigned NREG = 2 ** REG_ADDR_W;

  logic [NREG-1:0]       busy;
  logic [NREG-1:0]       busy_nxt;
  logic [XLEN-1:0]       op1;
  logic [XLEN-1:0]       op2;
  logic                  hz1;
  logic                  hz2;
  logic                  hazard;
  logic                  fire;
  logic                  sb_set;

  logic                  out_valid_q;
  logic [XLEN-1:0]       out_op1_q;
  logic [XLEN-1:0]       out_op2_q;
  logic [REG_ADDR_W-1:0] out_rd_q;
  logic                  out_write_q;
  logic                  out_load_q;
  logic [CTRL_W-1:0]     out_ctrl_q;
  logic [CNT_W-1:0]      stall_q;

  assign rf_raddr1 = bus.in_rs1;
  assign rf_raddr2 = bus.in_rs2;

  id_operand_unit_operand_resolve #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W), .NUM_FWD(NUM_FWD)) u_op1 (
    .read(bus.in_read1), .addr(bus.in_rs1), .imm(bus.in_imm1), .rf_rdata(rf_rdata1),
    .fwd_write(fwd_write), .fwd_ready(fwd_ready), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
    .wb_clr(wb_clr), .wb_clr_addr(wb_clr_addr), .wb_clr_data(wb_clr_data),
    .busy(busy[bus.in_rs1]), .data(op1), .hazard(hz1)
  );

  id_operand_unit_operand_resolve #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W), .NUM_FWD(NUM_FWD)) u_op2 (
    .read(bus.in_read2), .addr(bus.in_rs2), .imm(bus.in_imm2), .rf_rdata(rf_rdata2),
    .fwd_write(fwd_write), .fwd_ready(fwd_ready), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
    .wb_clr(wb_clr), .wb_clr_addr(wb_clr_addr), .wb_clr_data(wb_clr_data),
    .busy(busy[bus.in_rs2]), .data(op2), .hazard(hz2)
  );

  assign hazard       = bus.in_valid && (hz1 || hz2);
  assign bus.in_ready = !flush && !hazard && (!out_valid_q || bus.out_ready);
  assign fire         = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      out_op1_q   <= '0;
      out_op2_q   <= '0;
      out_rd_q    <= '0;
      out_write_q <= 1'b0;
      out_load_q  <= 1'b0;
      out_ctrl_q  <= '0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else if (fire) begin
      out_valid_q <= 1'b1;
      out_op1_q   <= op1;
      out_op2_q   <= op2;
      out_rd_q    <= bus.in_rd;
      out_write_q <= bus.in_write;
      out_load_q  <= bus.in_load;
      out_ctrl_q  <= bus.in_ctrl;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  // Only loads that actually hand off to execute become busy; set beats clear.
  assign sb_set = out_valid_q && bus.out_ready && !flush && out_load_q && out_write_q &&
                  (out_rd_q != REG_ADDR_W'(ZERO_REG));

  always_comb begin
    busy_nxt = busy;
    if (wb_clr) busy_nxt[wb_clr_addr] = 1'b0;
    if (sb_set) busy_nxt[out_rd_q] = 1'b1;
    busy_nxt[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) busy <= '0;
    else        busy <= busy_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q <= '0;
    end else if (hazard && !flush && (stall_q != '1)) begin
      stall_q <= stall_q + 1'b1;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_op1   = out_op1_q;
  assign bus.out_op2   = out_op2_q;
  assign bus.out_rd    = out_rd_q;
  assign bus.out_write = out_write_q;
  assign bus.out_load  = out_load_q;
  assign bus.out_ctrl  = out_ctrl_q;
  assign stall_cycles  = stall_q;

endmodule

// File: tb/tb_id_operand_unit.sv
// Scoreboard bench for id_operand_unit: directed scenarios followed by random
// traffic, checked against an operand-resolution reference model.
module tb_id_operand_unit;
  import id_operand_unit_pkg::*;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned RAW     = 5;
  localparam int unsigned NUM_FWD = 2;
  localparam int unsigned CTRL_W  = 16;
  localparam int unsigned CNT_W   = 2;
  localparam int unsigned NREG    = 32;
  localparam int          CNT_MAX = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  id_operand_unit_if #(.XLEN(XLEN), .REG_ADDR_W(RAW), .CTRL_W(CTRL_W)) bus ();

  logic [RAW-1:0]          rf_raddr1, rf_raddr2;
  logic [XLEN-1:0]         rf_rdata1, rf_rdata2;
  logic [NUM_FWD-1:0]      fwd_write, fwd_ready;
  logic [NUM_FWD*RAW-1:0]  fwd_addr;
  logic [NUM_FWD*XLEN-1:0] fwd_data;
  logic                    wb_clr;
  logic [RAW-1:0]          wb_clr_addr;
  logic [XLEN-1:0]         wb_clr_data;
  logic                    flush;
  logic [CNT_W-1:0]        stall_cycles;

  logic [XLEN-1:0] rf_mem [NREG];
  logic [RAW-1:0]  fa [NUM_FWD];
  logic [XLEN-1:0] fd [NUM_FWD];

  for (genvar g = 0; g < NUM_FWD; g++) begin : g_pack
    assign fwd_addr[g*RAW +: RAW]   = fa[g];
    assign fwd_data[g*XLEN +: XLEN] = fd[g];
  end

  assign rf_rdata1 = rf_mem[rf_raddr1];
  assign rf_rdata2 = rf_mem[rf_raddr2];

  id_operand_unit #(
    .XLEN(XLEN), .REG_ADDR_W(RAW), .NUM_FWD(NUM_FWD), .CTRL_W(CTRL_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .fwd_write(fwd_write), .fwd_ready(fwd_ready), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
    .wb_clr(wb_clr), .wb_clr_addr(wb_clr_addr), .wb_clr_data(wb_clr_data),
    .flush(flush), .stall_cycles(stall_cycles)
  );

  typedef struct packed {
    logic            hz;
    logic [XLEN-1:0] d;
  } res_t;

  typedef struct {
    logic [XLEN-1:0]   op1;
    logic [XLEN-1:0]   op2;
    logic [RAW-1:0]    rd;
    logic              w;
    logic              ld;
    logic [CTRL_W-1:0] ctrl;
  } exp_t;

  exp_t            exp_q[$];
  logic [NREG-1:0] busy_m;
  int              cnt_m;
  bit              occ_now;
  int              n_checks = 0;
  int              n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference operand lookup: immediate, x0, youngest matching bypass,
  // writeback, outstanding load, register file.
  function automatic res_t resolve(input logic rd, input logic [RAW-1:0] a, input logic [XLEN-1:0] imm);
    res_t r;
    r = '0;
    if (!rd) begin r.d = imm; return r; end
    if (a == 0) return r;
    for (int i = 0; i < NUM_FWD; i++) begin
      if (fwd_write[i] && fa[i] == a) begin
        if (fwd_ready[i]) r.d = fd[i];
        else r.hz = 1'b1;
        return r;
      end
    end
    if (wb_clr && wb_clr_addr == a) begin r.d = wb_clr_data; return r; end
    if (busy_m[a]) r.hz = 1'b1;
    else r.d = rf_mem[a];
    return r;
  endfunction

  // Stimulus-side model: evaluates the current inputs and pushes expectations.
  always begin
    res_t r1, r2;
    bit hz, rdy;
    exp_t e;
    @(posedge clk);
    #3;
    if (!reset) begin
      exp_q.delete();
      busy_m  = '0;
      cnt_m   = 0;
      occ_now = 1'b0;
    end else begin
      r1 = resolve(bus.in_read1, bus.in_rs1, bus.in_imm1);
      r2 = resolve(bus.in_read2, bus.in_rs2, bus.in_imm2);
      hz = bus.in_valid && (r1.hz || r2.hz);
      occ_now = (exp_q.size() != 0);
      rdy = !flush && !hz && (!occ_now || bus.out_ready);
      check("out_valid", 64'(bus.out_valid), 64'(occ_now));
      check("in_ready", 64'(bus.in_ready), 64'(rdy));
      check("rf_raddr", {rf_raddr1, rf_raddr2}, {bus.in_rs1, bus.in_rs2});
      check("stall_cycles", 64'(stall_cycles), 64'(cnt_m));
      if (hz && !flush && cnt_m < CNT_MAX) cnt_m++;
      if (bus.in_valid && rdy) begin
        e.op1 = r1.d; e.op2 = r2.d; e.rd = bus.in_rd;
        e.w = bus.in_write; e.ld = bus.in_load; e.ctrl = bus.in_ctrl;
        exp_q.push_back(e);
      end
    end
  end

  // Monitor: compares presented outputs with the head of the queue.
  always @(negedge clk) begin
    exp_t h;
    bit set_busy;
    if (reset) begin
      set_busy = 1'b0;
      if (bus.out_valid && !occ_now) begin
        check("out_valid_spurious", 64'(bus.out_valid), 64'(0));
      end else if (bus.out_valid) begin
        h = exp_q[0];
        check("out_op1", 64'(bus.out_op1), 64'(h.op1));
        check("out_op2", 64'(bus.out_op2), 64'(h.op2));
        check("out_meta", {bus.out_rd, bus.out_write, bus.out_load, bus.out_ctrl},
                          {h.rd, h.w, h.ld, h.ctrl});
      end
      if (occ_now && (flush || bus.out_ready)) begin
        h = exp_q.pop_front();
        set_busy = !flush && h.ld && h.w && (h.rd != 0);
      end
      if (wb_clr) busy_m[wb_clr_addr] = 1'b0;
      if (set_busy) busy_m[h.rd] = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0; bus.in_read1 = 1'b0; bus.in_read2 = 1'b0;
    bus.in_rs1 = '0; bus.in_rs2 = '0; bus.in_imm1 = '0; bus.in_imm2 = '0;
    bus.in_write = 1'b0; bus.in_rd = '0; bus.in_load = 1'b0; bus.in_ctrl = '0;
    bus.out_ready = 1'b1;
    fwd_write = '0; fwd_ready = '0;
    for (int i = 0; i < NUM_FWD; i++) begin fa[i] = '0; fd[i] = '0; end
    wb_clr = 1'b0; wb_clr_addr = '0; wb_clr_data = '0; flush = 1'b0;
  endtask

  task automatic instr(input logic r1, input logic [RAW-1:0] s1, input logic r2,
                       input logic [RAW-1:0] s2, input logic w, input logic [RAW-1:0] rd,
                       input logic ld);
    bus.in_valid = 1'b1; bus.in_read1 = r1; bus.in_rs1 = s1; bus.in_read2 = r2; bus.in_rs2 = s2;
    bus.in_write = w; bus.in_rd = rd; bus.in_load = ld;
    bus.in_imm1 = $urandom; bus.in_imm2 = $urandom; bus.in_ctrl = CTRL_W'($urandom);
  endtask

  initial begin
    for (int i = 0; i < NREG; i++) rf_mem[i] = $urandom;
    idle();
    #2;
    check("reset_out_valid", 64'(bus.out_valid), 64'(0));
    check("reset_stall", 64'(stall_cycles), 64'(0));
    check("reset_data", {bus.out_op1, bus.out_op2}, 64'(0));
    tick(); tick();
    reset = 1'b1;

    // Youngest bypass wins over an older match for the same register.
    instr(1, 1, 1, 2, 1, 3, 0);
    rf_mem[2] = 32'h5;
    fwd_write = 2'b11; fwd_ready = 2'b11;
    fa[0] = 1; fd[0] = 32'h11; fa[1] = 1; fd[1] = 32'h22;
    tick();
    check("t1_op1", 64'(bus.out_op1), 64'h11);
    check("t1_op2", 64'(bus.out_op2), 64'h5);
    idle(); tick();

    // Load-use stall on a not-yet-ready bypass source.
    instr(1, 4, 0, 0, 1, 6, 0);
    fwd_write = 2'b01; fwd_ready = 2'b00; fa[0] = 4;
    tick(); tick(); tick();
    fwd_ready = 2'b01; fd[0] = 32'h99;
    tick();
    check("t2_op1", 64'(bus.out_op1), 64'h99);
    idle(); tick();

    // Scoreboarded load, stall, release by writeback bypass.
    instr(1, 2, 0, 0, 1, 5, 1);
    tick();
    idle(); tick();
    instr(1, 5, 0, 0, 1, 8, 0);
    tick(); tick();
    wb_clr = 1'b1; wb_clr_addr = 5; wb_clr_data = 32'h1234;
    tick();
    check("t3_op1", 64'(bus.out_op1), 64'h1234);
    wb_clr = 1'b0;
    instr(1, 5, 0, 0, 1, 8, 0);
    tick();
    idle(); tick();

    // x0 never stalls nor forwards; load to x0 never becomes busy.
    instr(1, 0, 1, 0, 1, 9, 0);
    fwd_write = 2'b01; fwd_ready = 2'b00; fa[0] = 0;
    tick();
    check("t4_op1", 64'(bus.out_op1), 64'h0);
    idle();
    instr(0, 0, 0, 0, 1, 0, 1);
    tick();
    idle(); tick(); tick();

    // Backpressure hold, then flush of a held load leaves the scoreboard alone.
    instr(0, 0, 0, 0, 1, 7, 1);
    tick();
    bus.out_ready = 1'b0;
    instr(1, 3, 0, 0, 1, 10, 0);
    tick(); tick(); tick();
    flush = 1'b1;
    tick();
    flush = 1'b0; bus.out_ready = 1'b1;
    instr(1, 7, 0, 0, 1, 11, 0);
    tick();
    idle(); tick(); tick();

    // Saturating stall counter, then asynchronous reset mid-stall.
    reset = 1'b0; tick(); reset = 1'b1;
    instr(0, 0, 0, 0, 1, 7, 1);
    tick();
    instr(0, 0, 0, 0, 1, 12, 0);
    tick();
    bus.out_ready = 1'b0;
    instr(1, 7, 0, 0, 1, 13, 0);
    tick(); tick(); tick(); tick(); tick();
    check("t6_stall_sat", 64'(stall_cycles), 64'(CNT_MAX));
    #1 reset = 1'b0;
    #1;
    check("t6_async_valid", 64'(bus.out_valid), 64'(0));
    check("t6_async_stall", 64'(stall_cycles), 64'(0));
    tick(); tick();
    reset = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    idle(); tick();

    // Random traffic over a small register window to provoke hazards.
    for (int c = 0; c < 3000; c++) begin
      bus.in_valid = ($urandom % 4) != 0;
      bus.in_read1 = ($urandom % 4) != 0;
      bus.in_read2 = ($urandom % 4) != 0;
      bus.in_rs1 = RAW'($urandom % 8);
      bus.in_rs2 = RAW'($urandom % 8);
      bus.in_imm1 = $urandom; bus.in_imm2 = $urandom;
      bus.in_write = $urandom % 2;
      bus.in_rd = RAW'($urandom % 8);
      bus.in_load = ($urandom % 3) == 0;
      bus.in_ctrl = CTRL_W'($urandom);
      for (int i = 0; i < NUM_FWD; i++) begin
        fwd_write[i] = $urandom % 2;
        fwd_ready[i] = ($urandom % 4) != 0;
        fa[i] = RAW'($urandom % 8);
        fd[i] = $urandom;
      end
      wb_clr = ($urandom % 3) == 0;
      wb_clr_addr = RAW'($urandom % 8);
      wb_clr_data = $urandom;
      flush = ($urandom % 16) == 0;
      bus.out_ready = ($urandom % 4) != 0;
      if (($urandom % 8) == 0) rf_mem[$urandom % 8] = $urandom;
      tick();
    end
    idle(); tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/id_operand_unit.md
Name: id_operand_unit

Overview:
Parametrised operand-resolution and hazard stage that sits between instruction decode and execute. It generalises the decode-stage forwarding logic:
- NUM_FWD prioritised bypass sources instead of fixed EX/MEM.
- A per-register pending-load scoreboard for variable-latency memory.
- A valid/ready handshaked ID/EX pipeline register with flush and bubble insertion.

It replaces ad-hoc stall muxing with one registered, back-pressure-aware stage.

Parameters:
XLEN, 32, data/operand width
REG_ADDR_W, 5, register address width (2**REG_ADDR_W architectural registers)
NUM_FWD, 2, bypass sources; index 0 is youngest (EX), highest priority
CTRL_W, 16, opaque decoded control bundle passed to execute (alusel/aluop/offset fields)
CNT_W, 16, stall-cycle counter width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
in_valid  in  1  decoded instruction present
in_ready  out  1  stage accepts instruction this cycle
in_read1 / in_read2  in  1 each  operand uses register rs1 / rs2
in_rs1 / in_rs2  in  REG_ADDR_W each  source register addresses
in_imm1 / in_imm2  in  XLEN each  operand values used when the matching read flag is 0
in_write  in  1  instruction writes rd
in_rd  in  REG_ADDR_W  destination register
in_load  in  1  instruction is a load
in_ctrl  in  CTRL_W  pass-through control
rf_raddr1 / rf_raddr2  out  REG_ADDR_W each  register-file read addresses (combinational = in_rs1/in_rs2)
rf_rdata1 / rf_rdata2  in  XLEN each  register-file read data (combinational)
fwd_write  in  NUM_FWD  source i holds a pending write
fwd_ready  in  NUM_FWD  source i data is already computed
fwd_addr  in  NUM_FWD*REG_ADDR_W  source i destination; slice i at [i*REG_ADDR_W +: REG_ADDR_W]
fwd_data  in  NUM_FWD*XLEN  source i data
wb_clr  in  1  load result is being written back this cycle
wb_clr_addr  in  REG_ADDR_W  register of that writeback
wb_clr_data  in  XLEN  writeback data
flush  in  1  discard ID/EX contents (branch redirect)
out_valid  out  1  ID/EX register holds an instruction
out_ready  in  1  execute accepts this cycle
out_op1 / out_op2  out  XLEN each  resolved operands
out_rd, out_write, out_load, out_ctrl  out  registered copies of the inputs
stall_cycles  out  CNT_W  saturating count of hazard-stall cycles

Behaviour:
- Reset (reset=0, asynchronous):
  - All registered outputs are 0.
  - All scoreboard busy bits are 0.
  - stall_cycles is 0.
- Operand resolution (combinational, done independently for each of operands 1 and 2, first matching rule wins):
  1. read=0 -> imm.
  2. addr==0 -> 0, never a hazard.
  3. Lowest index i with fwd_write[i] && fwd_addr[i]==addr: fwd_ready[i] ? fwd_data[i] : hazard.
  4. wb_clr && wb_clr_addr==addr -> wb_clr_data.
  5. busy[addr] -> hazard.
  6. Otherwise -> rf_rdata.
- hazard = in_valid && (hz1 || hz2).
- in_ready = !flush && !hazard && (!out_valid || out_ready).
- fire = in_valid && in_ready.
- ID/EX register, priority per edge:
  - flush -> out_valid<=0, data unchanged.
  - else fire -> capture all outputs, out_valid<=1. Latency from input to output is 1 cycle.
  - else out_ready -> out_valid<=0 (bubble).
  - else hold all outputs.
- Output data is stable while out_valid && !out_ready; it never changes under backpressure.
- Scoreboard (2**REG_ADDR_W bits):
  - set: out_valid && out_ready && !flush && out_load && out_write && out_rd!=0 sets busy[out_rd].
  - clear: wb_clr clears busy[wb_clr_addr].
  - Set and clear of the same address in one cycle -> set wins.
  - busy[0] is permanently 0.
  - flush never touches the scoreboard: only loads that already left ID/EX are tracked.
- stall_cycles increments when in_valid && hazard && !flush; it saturates at all-ones.
- Register x0 never forwards, never stalls, and never becomes busy.

Decomposition:
- Shared package: XLEN/REG_ADDR_W defaults, CTRL_W field layout (alusel, aluop, mem_offset positions), and the ZERO_REG constant.
- Sub-module operand_resolve (priority bypass mux plus hazard flag, parameterised by NUM_FWD):
  - instantiated twice, once per operand;
  - it reads the scoreboard bit and the wb bypass as inputs.

Test Plan:
1. ADD x3,x1,x2 with fwd0 = {write=1, ready=1, addr=1, data=0x11} and fwd1 = {write=1, ready=1, addr=1, data=0x22}, rf_rdata2=5 -> next cycle out_op1=0x11 (youngest wins), out_op2=5, out_valid=1.
2. Load-use: fwd0 = {write=1, ready=0, addr=4}, in_rs1=4 -> in_ready=0 and stall_cycles increments each cycle; when fwd_ready=1 and fwd_data=0x99 -> fires, out_op1=0x99.
3. Load LW x5 leaves ID/EX -> busy[5]=1. Later instruction reads x5 with no fwd match -> stalls. Then wb_clr with addr=5, data=0x1234 -> same cycle fires, out_op1=0x1234; busy[5]=0 next cycle.
4. in_rs1=0 with fwd0 = {addr=0, ready=0} -> no stall, out_op1=0; a load with rd=0 leaving the stage leaves busy[0]=0.
5. out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and outputs unchanged. Then flush=1 -> out_valid=0 next edge and busy unchanged.
6. Reset pulled low mid-stall with busy[7]=1 -> immediately out_valid=0, busy cleared, stall_cycles=0. With CNT_W=2 and 5 stall cycles -> stall_cycles=3.
